// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: sequencer states, address stride and
// the phase-ordering helper used to skip phases with zero length.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_I    = 3'd1,
    LOAD_D    = 3'd2,
    RUN       = 3'd3,
    DUMP_RD   = 3'd4,
    DUMP_WAIT = 3'd5,
    DUMP_OUT  = 3'd6,
    FIN       = 3'd7
  } state_e;

  localparam int WORD_BYTES = 8;

  // Phases run in enum order, so the next phase is the first later one with work.
  function automatic state_e next_phase(input state_e from,
                                        input logic   i_nz,
                                        input logic   d_nz,
                                        input logic   r_nz,
                                        input logic   u_nz);
    state_e nxt;
    nxt = FIN;
    if (from < LOAD_I && i_nz)       nxt = LOAD_I;
    else if (from < LOAD_D && d_nz)  nxt = LOAD_D;
    else if (from < RUN && r_nz)     nxt = RUN;
    else if (from < DUMP_RD && u_nz) nxt = DUMP_RD;
    return nxt;
  endfunction

endpackage

// File: rtl/prog_loader_word_counter.sv
// Loadable up/down counter; last_o flags that the next step reaches limit_i.
module loader_word_counter #(
  parameter int W    = 11,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] count_q, count_d, step_val;

  assign step_val = DOWN ? (count_q - W'(1)) : (count_q + W'(1));

  always_comb begin
    count_d = count_q;
    if (load_i)      count_d = load_val_i;
    else if (step_i) count_d = step_val;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;
  assign last_o  = (step_val == limit_i);

endmodule

// File: rtl/prog_loader.sv
// Host-side sequencer: loads instruction/data memory images into the cpu,
// runs it for a fixed cycle count, then streams data memory back out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic                          start,
  input  logic [$clog2(IMEM_WORDS):0]   imem_len,
  input  logic [$clog2(DMEM_WORDS):0]   dmem_len,
  input  logic [$clog2(DMEM_WORDS):0]   dump_len,
  input  logic [CNT_W-1:0]              run_cycles,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [63:0]                   s_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [63:0]                   m_data,
  output logic                          cpu_enable,
  output logic [63:0]                   addr_ext,
  output logic                          wen_ext,
  output logic                          ren_ext,
  output logic [63:0]                   wdata_ext,
  output logic [63:0]                   addr_ext_2,
  output logic                          wen_ext_2,
  output logic                          ren_ext_2,
  output logic [63:0]                   wdata_ext_2,
  input  logic [63:0]                   rdata_ext_2,
  output logic                          busy,
  output logic                          done
);

  localparam int IW = $clog2(IMEM_WORDS) + 1;
  localparam int DW = $clog2(DMEM_WORDS) + 1;
  localparam int XW = (IW > DW) ? IW : DW;

  state_e          state_q, state_d;
  logic [IW-1:0]   imem_len_q;
  logic [DW-1:0]   dmem_len_q, dump_len_q;
  logic [63:0]     m_data_q;

  logic [IW-1:0]   imem_clamp;
  logic [DW-1:0]   dmem_clamp, dump_clamp;
  logic            start_acc;
  logic            i_nz, d_nz, r_nz, u_nz;

  logic [XW-1:0]   idx, idx_limit;
  logic            idx_last, idx_step, idx_load;
  logic [63:0]     idx_addr;
  logic [CNT_W-1:0] run_cnt;
  logic            run_last;

  assign imem_clamp = (imem_len > IW'(IMEM_WORDS)) ? IW'(IMEM_WORDS) : imem_len;
  assign dmem_clamp = (dmem_len > DW'(DMEM_WORDS)) ? DW'(DMEM_WORDS) : dmem_len;
  assign dump_clamp = (dump_len > DW'(DMEM_WORDS)) ? DW'(DMEM_WORDS) : dump_len;

  assign start_acc = (state_q == IDLE) && start;

  // In IDLE the captured copies are stale, so phase skipping looks at the live inputs.
  assign i_nz = (state_q == IDLE) ? (|imem_len)   : (|imem_len_q);
  assign d_nz = (state_q == IDLE) ? (|dmem_len)   : (|dmem_len_q);
  assign r_nz = (state_q == IDLE) ? (|run_cycles) : (|run_cnt);
  assign u_nz = (state_q == IDLE) ? (|dump_len)   : (|dump_len_q);

  always_comb begin
    idx_limit = XW'(dump_len_q);
    if (state_q == LOAD_I)      idx_limit = XW'(imem_len_q);
    else if (state_q == LOAD_D) idx_limit = XW'(dmem_len_q);
  end

  assign idx_step = (((state_q == LOAD_I) || (state_q == LOAD_D)) && s_valid) ||
                    ((state_q == DUMP_OUT) && m_ready);
  assign idx_load = start_acc || (idx_step && idx_last);
  assign idx_addr = 64'(idx) * 64'(WORD_BYTES);

  loader_word_counter #(.W(XW), .DOWN(1'b0)) u_idx (
    .clk        (clk),
    .arst_n     (arst_n),
    .load_i     (idx_load),
    .load_val_i ('0),
    .step_i     (idx_step),
    .limit_i    (idx_limit),
    .count_o    (idx),
    .last_o     (idx_last)
  );

  // The run counter doubles as the captured copy of run_cycles.
  loader_word_counter #(.W(CNT_W), .DOWN(1'b1)) u_run (
    .clk        (clk),
    .arst_n     (arst_n),
    .load_i     (start_acc),
    .load_val_i (run_cycles),
    .step_i     (state_q == RUN),
    .limit_i    ('0),
    .count_o    (run_cnt),
    .last_o     (run_last)
  );

  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    cpu_enable  = 1'b0;
    addr_ext    = '0;
    wen_ext     = 1'b0;
    wdata_ext   = '0;
    addr_ext_2  = '0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = '0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = next_phase(IDLE, i_nz, d_nz, r_nz, u_nz);
      end
      LOAD_I: begin
        s_ready  = 1'b1;
        addr_ext = idx_addr;
        if (s_valid) begin
          wen_ext   = 1'b1;
          wdata_ext = s_data;
          if (idx_last) state_d = next_phase(LOAD_I, i_nz, d_nz, r_nz, u_nz);
        end
      end
      LOAD_D: begin
        s_ready    = 1'b1;
        addr_ext_2 = idx_addr;
        if (s_valid) begin
          wen_ext_2   = 1'b1;
          wdata_ext_2 = s_data;
          if (idx_last) state_d = next_phase(LOAD_D, i_nz, d_nz, r_nz, u_nz);
        end
      end
      RUN: begin
        cpu_enable = 1'b1;
        if (run_last) state_d = next_phase(RUN, i_nz, d_nz, r_nz, u_nz);
      end
      DUMP_RD: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = idx_addr;
        state_d    = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        state_d = DUMP_OUT;
      end
      DUMP_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = idx_last ? FIN : DUMP_RD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      imem_len_q <= '0;
      dmem_len_q <= '0;
      dump_len_q <= '0;
      m_data_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        imem_len_q <= imem_clamp;
        dmem_len_q <= dmem_clamp;
        dump_len_q <= dump_clamp;
      end
      if (state_q == DUMP_WAIT) m_data_q <= rdata_ext_2;
    end
  end

  assign m_data  = m_data_q;
  assign ren_ext = 1'b0;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 1-cycle-latency data memory read model.
module tb_prog_loader;

  localparam int IW = 10;
  localparam int DW = 11;
  localparam logic [63:0] WORD_X = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] WORD_Y = 64'hDEAD_BEEF_0000_0002;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] imem_len = '0;
  logic [DW-1:0] dmem_len = '0;
  logic [DW-1:0] dump_len = '0;
  logic [31:0]   run_cycles = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [63:0]   s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [63:0]   m_data;
  logic          cpu_enable;
  logic [63:0]   addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic          wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [63:0]   rdata_ext_2 = '0;
  logic          busy, done;

  logic [63:0]   dmemModel [0:15];

  int checkCount = 0;
  int errorCount = 0;

  prog_loader dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_len(imem_len), .dmem_len(dmem_len), .dump_len(dump_len),
    .run_cycles(run_cycles),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= dmemModel[addr_ext_2[6:3]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start for one cycle; returns one cycle later with the first phase entered.
  task automatic applyStimulus(input int iLen, input int dLen, input int uLen, input int runC);
    imem_len   = IW'(iLen);
    dmem_len   = DW'(dLen);
    dump_len   = DW'(uLen);
    run_cycles = 32'(runC);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic runUntilDone(input int maxCycles, output int enCount, output int wenCount,
                              output int busyLow, output int doneCycle);
    enCount   = 0;
    wenCount  = 0;
    busyLow   = 0;
    doneCycle = -1;
    for (int k = 0; k < maxCycles; k++) begin
      #1;
      if (cpu_enable) enCount++;
      if (wen_ext || wen_ext_2) wenCount++;
      if (!busy) busyLow++;
      if (done) begin
        doneCycle = k;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int enC, wenC, busyL, doneC;
    int iWrites, dWrites, gapWrites, bothHigh, doneN;
    logic [63:0] iAddr [2];
    logic [63:0] iData [2];
    logic [63:0] dAddr [2];
    logic [63:0] dData [2];

    for (int i = 0; i < 16; i++) dmemModel[i] = 64'h0;
    dmemModel[0] = WORD_X;
    dmemModel[1] = WORD_Y;

    #1 arst_n = 1'b0;
    #2;
    checkOutput("rst_busy",   64'(busy), 64'd0);
    checkOutput("rst_done",   64'(done), 64'd0);
    checkOutput("rst_sready", 64'(s_ready), 64'd0);
    checkOutput("rst_mvalid", 64'(m_valid), 64'd0);
    checkOutput("rst_cpuen",  64'(cpu_enable), 64'd0);
    checkOutput("rst_mdata",  m_data, 64'd0);
    checkOutput("rst_addr",   addr_ext_2, 64'd0);
    checkOutput("rst_ren",    64'(ren_ext), 64'd0);
    #9 arst_n = 1'b1;
    tick();

    $display("[TB] all-zero lengths go straight to done");
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("zero_done", 64'(done), 64'd1);
    tick();
    #1;
    checkOutput("zero_done_clr", 64'(done), 64'd0);
    checkOutput("zero_idle",     64'(busy), 64'd0);
    tick();

    $display("[TB] imem load of three words");
    applyStimulus(3, 0, 0, 0);
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 64'hAAAA_0000_0000_0000 + 64'(i);
      #1;
      checkOutput($sformatf("ld_wen%0d", i),   64'(wen_ext), 64'd1);
      checkOutput($sformatf("ld_addr%0d", i),  addr_ext, 64'(i * 8));
      checkOutput($sformatf("ld_wdata%0d", i), wdata_ext, 64'hAAAA_0000_0000_0000 + 64'(i));
      checkOutput($sformatf("ld_wen2_%0d", i), 64'(wen_ext_2), 64'd0);
      tick();
    end
    #1;
    checkOutput("ld_done",   64'(done), 64'd1);
    checkOutput("ld_nowen",  64'(wen_ext), 64'd0);
    checkOutput("ld_sready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    tick();
    #1;
    checkOutput("ld_done_clr", 64'(done), 64'd0);
    tick();

    $display("[TB] imem+dmem load with gaps in s_valid");
    applyStimulus(2, 2, 0, 0);
    iWrites = 0; dWrites = 0; gapWrites = 0; bothHigh = 0; doneN = -1;
    for (int n = 0; n < 20; n++) begin
      s_valid = (n % 2 == 0);
      s_data  = 64'h1000 + 64'(n);
      #1;
      if (wen_ext && wen_ext_2) bothHigh++;
      if (!s_valid && (wen_ext || wen_ext_2)) gapWrites++;
      if (wen_ext) begin
        if (iWrites < 2) begin
          iAddr[iWrites] = addr_ext;
          iData[iWrites] = wdata_ext;
        end
        iWrites++;
      end
      if (wen_ext_2) begin
        if (dWrites < 2) begin
          dAddr[dWrites] = addr_ext_2;
          dData[dWrites] = wdata_ext_2;
        end
        dWrites++;
      end
      if (done) begin
        doneN = n;
        break;
      end
      tick();
    end
    s_valid = 1'b0;
    checkOutput("gap_iwrites", 64'(iWrites), 64'd2);
    checkOutput("gap_dwrites", 64'(dWrites), 64'd2);
    checkOutput("gap_nowrite", 64'(gapWrites), 64'd0);
    checkOutput("gap_both",    64'(bothHigh), 64'd0);
    checkOutput("gap_iaddr1",  iAddr[1], 64'd8);
    checkOutput("gap_idata1",  iData[1], 64'h1002);
    checkOutput("gap_daddr0",  dAddr[0], 64'd0);
    checkOutput("gap_ddata0",  dData[0], 64'h1004);
    checkOutput("gap_daddr1",  dAddr[1], 64'd8);
    checkOutput("gap_ddata1",  dData[1], 64'h1006);
    checkOutput("gap_donecyc", 64'(doneN), 64'd7);
    tick();

    $display("[TB] run phase only");
    applyStimulus(0, 0, 0, 5);
    runUntilDone(30, enC, wenC, busyL, doneC);
    checkOutput("run_en",     64'(enC), 64'd5);
    checkOutput("run_wen",    64'(wenC), 64'd0);
    checkOutput("run_busy",   64'(busyL), 64'd0);
    checkOutput("run_donecy", 64'(doneC), 64'd5);
    tick();
    #1;
    checkOutput("run_after_en", 64'(cpu_enable), 64'd0);
    tick();

    $display("[TB] dump with backpressure");
    applyStimulus(0, 0, 2, 0);
    m_ready = 1'b0;
    #1;
    checkOutput("dmp_ren0",  64'(ren_ext_2), 64'd1);
    checkOutput("dmp_addr0", addr_ext_2, 64'd0);
    checkOutput("dmp_mv_rd", 64'(m_valid), 64'd0);
    checkOutput("dmp_renI",  64'(ren_ext), 64'd0);
    tick();
    #1;
    checkOutput("dmp_wait_ren", 64'(ren_ext_2), 64'd0);
    checkOutput("dmp_wait_mv",  64'(m_valid), 64'd0);
    tick();
    for (int j = 0; j < 4; j++) begin
      #1;
      checkOutput($sformatf("dmp_hold_mv%0d", j), 64'(m_valid), 64'd1);
      checkOutput($sformatf("dmp_hold_x%0d", j),  m_data, WORD_X);
      if (j == 3) m_ready = 1'b1;
      tick();
    end
    m_ready = 1'b0;
    #1;
    checkOutput("dmp_ren1",  64'(ren_ext_2), 64'd1);
    checkOutput("dmp_addr1", addr_ext_2, 64'd8);
    checkOutput("dmp_nodone", 64'(done), 64'd0);
    tick();
    tick();
    #1;
    checkOutput("dmp_mv_y", 64'(m_valid), 64'd1);
    checkOutput("dmp_y",    m_data, WORD_Y);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    checkOutput("dmp_done",    64'(done), 64'd1);
    checkOutput("dmp_mv_done", 64'(m_valid), 64'd0);
    tick();
    #1;
    checkOutput("dmp_idle", 64'(busy), 64'd0);
    tick();

    $display("[TB] reset during run, then clean restart");
    applyStimulus(0, 0, 0, 10);
    tick();
    tick();
    #1;
    checkOutput("arst_pre_en", 64'(cpu_enable), 64'd1);
    arst_n = 1'b0;
    #1;
    checkOutput("arst_en",     64'(cpu_enable), 64'd0);
    checkOutput("arst_busy",   64'(busy), 64'd0);
    checkOutput("arst_done",   64'(done), 64'd0);
    checkOutput("arst_sready", 64'(s_ready), 64'd0);
    checkOutput("arst_mvalid", 64'(m_valid), 64'd0);
    #2 arst_n = 1'b1;
    tick();
    s_valid = 1'b1;
    s_data  = 64'h5555;
    applyStimulus(1, 0, 0, 2);
    runUntilDone(20, enC, wenC, busyL, doneC);
    s_valid = 1'b0;
    checkOutput("rst2_en",     64'(enC), 64'd2);
    checkOutput("rst2_wen",    64'(wenC), 64'd1);
    checkOutput("rst2_donecy", 64'(doneC), 64'd3);
    tick();

    $display("[TB] start while busy is ignored");
    applyStimulus(0, 0, 0, 3);
    #1;
    checkOutput("busy_en0", 64'(cpu_enable), 64'd1);
    imem_len   = IW'(5);
    dump_len   = DW'(4);
    run_cycles = 32'd9;
    start      = 1'b1;
    tick();
    start = 1'b0;
    runUntilDone(20, enC, wenC, busyL, doneC);
    checkOutput("busy_en",     64'(enC), 64'd2);
    checkOutput("busy_wen",    64'(wenC), 64'd0);
    checkOutput("busy_donecy", 64'(doneC), 64'd2);
    tick();
    #1;
    checkOutput("busy_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
